// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
//   Bridges the HPS ioctl download port to the core's ROM/PROM memories.
//   Each accepted 16-bit ioctl word is split into two byte writes (low byte at
//   ioctl_addr, high byte at ioctl_addr+1). Every byte is decoded into the CPU
//   ROM, GFX ROM or colour PROM region and written with a region-local address.
//   The HPS is stalled with ioctl_wait while a word is being emitted.
//
// Ports
//   clk_sys        system clock, rising edge
//   reset_n        asynchronous active-low reset
//   ioctl_download HPS download active
//   ioctl_index    download target index (only ROM_INDEX is accepted)
//   ioctl_wr       single-cycle word write strobe
//   ioctl_addr     byte address of the word's low byte (even)
//   ioctl_dout     word data, [7:0] -> addr, [15:8] -> addr+1
//   ioctl_wait     stall to the HPS while a word is in flight
//   rom_addr       region-local byte address (held when no strobe)
//   rom_data       byte to write (held when no strobe)
//   cpu_we/gfx_we/prom_we  region write strobes, at most one high
//   dl_busy        accepted download in progress
//   dl_done        one-cycle pulse at end of download
//   byte_count     in-range bytes written in current/last download (saturating)
//   overflow       sticky: out-of-range byte or write while stalled
// -----------------------------------------------------------------------------
module rom_loader #(
   parameter int CPU_SIZE  = 32768,
   parameter int GFX_SIZE  = 16384,
   parameter int PROM_SIZE = 288,
   parameter int ROM_INDEX = 0
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic        ioctl_wait,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        cpu_we,
   output logic        gfx_we,
   output logic        prom_we,
   output logic        dl_busy,
   output logic        dl_done,
   output logic [16:0] byte_count,
   output logic        overflow
);

   localparam logic [26:0] CPU_END  = 27'(CPU_SIZE);
   localparam logic [26:0] GFX_END  = 27'(CPU_SIZE + GFX_SIZE);
   localparam logic [26:0] PROM_END = 27'(CPU_SIZE + GFX_SIZE + PROM_SIZE);
   localparam logic [15:0] GFX_OFS  = 16'(CPU_SIZE);
   localparam logic [15:0] PROM_OFS = 16'(CPU_SIZE + GFX_SIZE);

   typedef enum logic [1:0] {IDLE, LO, HI, FINISH} state_t;

   state_t      state_q, state_d;
   logic [26:0] hi_addr_q, hi_addr_d;
   logic [7:0]  hi_data_q, hi_data_d;
   logic        wait_q, wait_d;
   logic [15:0] rom_addr_q, rom_addr_d;
   logic [7:0]  rom_data_q, rom_data_d;
   logic        cpu_we_q, cpu_we_d;
   logic        gfx_we_q, gfx_we_d;
   logic        prom_we_q, prom_we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [16:0] count_q, count_d;
   logic        ovf_q, ovf_d;
   logic        acc_q;

   logic        accept;
   logic        start;
   logic        wr_acc;
   logic        emit;
   logic [26:0] byte_addr;
   logic [7:0]  byte_data;

   assign accept = ioctl_download && (ioctl_index == 8'(ROM_INDEX));
   assign start  = accept && !acc_q;
   assign wr_acc = accept && ioctl_wr;

   always_comb begin
      state_d    = state_q;
      hi_addr_d  = hi_addr_q;
      hi_data_d  = hi_data_q;
      wait_d     = wait_q;
      rom_addr_d = rom_addr_q;
      rom_data_d = rom_data_q;
      cpu_we_d   = 1'b0;
      gfx_we_d   = 1'b0;
      prom_we_d  = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      count_d    = count_q;
      ovf_d      = ovf_q;
      emit       = 1'b0;
      byte_addr  = ioctl_addr;
      byte_data  = ioctl_dout[7:0];

      if (start) begin
         count_d = '0;
         ovf_d   = 1'b0;
         busy_d  = 1'b1;
      end

      // The output registers are loaded one state ahead: the low byte is
      // decoded on the ioctl_wr edge so its strobe is visible during LO, and
      // the high byte is decoded on the LO edge so it is visible during HI.
      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               emit      = 1'b1;
               hi_addr_d = ioctl_addr + 27'd1;
               hi_data_d = ioctl_dout[15:8];
               wait_d    = 1'b1;
               state_d   = LO;
            end else if (!accept && busy_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end
         end
         LO: begin
            emit      = 1'b1;
            byte_addr = hi_addr_q;
            byte_data = hi_data_q;
            if (wr_acc) ovf_d = 1'b1;
            state_d = HI;
         end
         HI: begin
            wait_d = 1'b0;
            if (wr_acc) ovf_d = 1'b1;
            // A download that dropped mid-word finishes once both bytes are out.
            if (!accept && busy_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end else begin
               state_d = IDLE;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (emit) begin
         if (byte_addr < CPU_END) begin
            cpu_we_d   = 1'b1;
            rom_addr_d = byte_addr[15:0];
         end else if (byte_addr < GFX_END) begin
            gfx_we_d   = 1'b1;
            rom_addr_d = byte_addr[15:0] - GFX_OFS;
         end else if (byte_addr < PROM_END) begin
            prom_we_d  = 1'b1;
            rom_addr_d = byte_addr[15:0] - PROM_OFS;
         end else begin
            ovf_d = 1'b1;
         end
         if (cpu_we_d || gfx_we_d || prom_we_d) begin
            rom_data_d = byte_data;
            if (count_d != '1) count_d = count_d + 17'd1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         hi_addr_q  <= '0;
         hi_data_q  <= '0;
         wait_q     <= 1'b0;
         rom_addr_q <= '0;
         rom_data_q <= '0;
         cpu_we_q   <= 1'b0;
         gfx_we_q   <= 1'b0;
         prom_we_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         acc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_addr_q  <= hi_addr_d;
         hi_data_q  <= hi_data_d;
         wait_q     <= wait_d;
         rom_addr_q <= rom_addr_d;
         rom_data_q <= rom_data_d;
         cpu_we_q   <= cpu_we_d;
         gfx_we_q   <= gfx_we_d;
         prom_we_q  <= prom_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         acc_q      <= accept;
      end
   end

   assign ioctl_wait = wait_q;
   assign rom_addr   = rom_addr_q;
   assign rom_data   = rom_data_q;
   assign cpu_we     = cpu_we_q;
   assign gfx_we     = gfx_we_q;
   assign prom_we    = prom_we_q;
   assign dl_busy    = busy_q;
   assign dl_done    = done_q;
   assign byte_count = count_q;
   assign overflow   = ovf_q;

endmodule
